// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: MEM/WB pipeline vs. one buffered
// multi-cycle result, with starvation-forced single-cycle pipeline stall.
module wb_write_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  wb_rd_in,
    input  logic [63:0] wb_dw_in,
    input  logic        wb_regwrite_in,
    input  logic        mc_valid,
    input  logic [4:0]  mc_rd,
    input  logic [63:0] mc_data,
    output logic        mc_ready,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [63:0] rf_wd,
    output logic        stall_pipe,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FORCE
    } state_t;

    localparam logic [4:0] XZR      = 5'd31;
    localparam logic [3:0] CNT_LAST = 4'(STARVE_MAX - 1);
    localparam logic [3:0] CNT_SAT  = 4'hF;

    state_t      state_q, state_d;
    logic        active_q;
    logic [4:0]  buf_rd_q, buf_rd_d;
    logic [63:0] buf_data_q, buf_data_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        pipe_req;
    logic        buf_grant;
    logic        we_raw;
    logic        stall_raw;
    logic        ready_raw;
    logic        busy_raw;

    assign pipe_req = wb_regwrite_in && (wb_rd_in != XZR);

    always_comb begin
        state_d    = state_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        cnt_d      = cnt_q;
        buf_grant  = 1'b0;
        we_raw     = pipe_req;
        stall_raw  = 1'b0;
        ready_raw  = 1'b0;
        busy_raw   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready_raw = 1'b1;
                if (mc_valid) begin
                    buf_rd_d   = mc_rd;
                    buf_data_d = mc_data;
                    cnt_d      = 4'd0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                busy_raw = 1'b1;
                if (buf_rd_q == XZR) begin
                    state_d = IDLE;
                end else if (!pipe_req) begin
                    buf_grant = 1'b1;
                    we_raw    = 1'b1;
                    state_d   = IDLE;
                end else if (wb_rd_in == buf_rd_q) begin
                    // older buffered value is superseded by the pipeline write
                    state_d = IDLE;
                end else begin
                    cnt_d = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = FORCE;
                    end
                end
            end
            FORCE: begin
                busy_raw  = 1'b1;
                stall_raw = 1'b1;
                buf_grant = 1'b1;
                we_raw    = (buf_rd_q != XZR);
                cnt_d     = 4'd0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // active_q delays reset release to the next edge and masks outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q   <= 1'b0;
            state_q    <= IDLE;
            buf_rd_q   <= 5'd0;
            buf_data_q <= 64'd0;
            cnt_q      <= 4'd0;
        end else if (!active_q) begin
            active_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        rf_we      = 1'b0;
        rf_wa      = 5'd0;
        rf_wd      = 64'd0;
        stall_pipe = 1'b0;
        mc_ready   = 1'b0;
        busy       = 1'b0;
        if (active_q) begin
            rf_we      = we_raw;
            rf_wa      = buf_grant ? buf_rd_q : wb_rd_in;
            rf_wd      = buf_grant ? buf_data_q : wb_dw_in;
            stall_pipe = stall_raw;
            mc_ready   = ready_raw;
            busy       = busy_raw;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Testbench for wb_write_arbiter: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_wb_write_arbiter;

    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  wb_rd_in = '0;
    logic [63:0] wb_dw_in = '0;
    logic        wb_regwrite_in = 1'b0;
    logic        mc_valid = 1'b0;
    logic [4:0]  mc_rd = '0;
    logic [63:0] mc_data = '0;
    logic        mc_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [63:0] rf_wd;
    logic        stall_pipe;
    logic        busy;

    int checks = 0;
    int errors = 0;

    wb_write_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk),
        .reset(reset),
        .wb_rd_in(wb_rd_in),
        .wb_dw_in(wb_dw_in),
        .wb_regwrite_in(wb_regwrite_in),
        .mc_valid(mc_valid),
        .mc_rd(mc_rd),
        .mc_data(mc_data),
        .mc_ready(mc_ready),
        .rf_we(rf_we),
        .rf_wa(rf_wa),
        .rf_wd(rf_wd),
        .stall_pipe(stall_pipe),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic we, input logic [4:0] rd,
                         input logic [63:0] dw, input logic mv,
                         input logic [4:0] mrd, input logic [63:0] md);
        @(negedge clk);
        wb_regwrite_in = we;
        wb_rd_in       = rd;
        wb_dw_in       = dw;
        mc_valid       = mv;
        mc_rd          = mrd;
        mc_data        = md;
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive($urandom, 5'($urandom), {$urandom, $urandom},
                  $urandom, 5'($urandom), {$urandom, $urandom});
            checks++;
            if ({rf_we, stall_pipe, mc_ready, busy, rf_wa, rf_wd} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: we=%0b st=%0b rdy=%0b busy=%0b wa=%0d wd=%h want all 0",
                         rf_we, stall_pipe, mc_ready, busy, rf_wa, rf_wd);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        wb_regwrite_in = 0;
        mc_valid = 0;
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (mc_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%0b busy=%0b want 1 0", mc_ready, busy);
        end
    endtask

    task automatic test_idle_write;
        drive(1, 5, 64'hDEAD, 0, 0, 0);
        checks++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 64'hDEAD) begin
            errors++;
            $display("FAIL idle_x5: we=%0b wa=%0d wd=%h want 1 5 dead", rf_we, rf_wa, rf_wd);
        end
        drive(1, 31, 64'hDEAD, 0, 0, 0);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_x31: we=%0b want 0", rf_we);
        end
    endtask

    task automatic test_drain;
        drive(0, 0, 0, 1, 7, 64'h1234);
        checks++;
        if (mc_ready !== 1'b1 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL drain_accept: rdy=%0b we=%0b want 1 0", mc_ready, rf_we);
        end
        drive(0, 3, 64'h99, 0, 0, 0);
        checks++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 64'h1234 || busy !== 1'b1 || mc_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_write: we=%0b wa=%0d wd=%h busy=%0b rdy=%0b want 1 7 1234 1 0",
                     rf_we, rf_wa, rf_wd, busy, mc_ready);
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++;
        if (busy !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL drain_done: busy=%0b we=%0b want 0 0", busy, rf_we);
        end
    endtask

    task automatic test_starve;
        drive(0, 0, 0, 1, 9, 64'h9999);
        for (int i = 1; i <= 3; i++) begin
            drive(1, 5'(i), 64'(i * 16), 0, 0, 0);
            checks++;
            if (rf_we !== 1'b1 || rf_wa !== 5'(i) || stall_pipe !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL starve_pipe%0d: we=%0b wa=%0d st=%0b busy=%0b want 1 %0d 0 1",
                         i, rf_we, rf_wa, stall_pipe, busy, i);
            end
        end
        drive(1, 10, 64'hA0A0, 0, 0, 0);
        checks++;
        if (stall_pipe !== 1'b1 || rf_we !== 1'b1 || rf_wa !== 5'd9 || rf_wd !== 64'h9999) begin
            errors++;
            $display("FAIL starve_force: st=%0b we=%0b wa=%0d wd=%h want 1 1 9 9999",
                     stall_pipe, rf_we, rf_wa, rf_wd);
        end
        drive(1, 10, 64'hA0A0, 0, 0, 0);
        checks++;
        if (stall_pipe !== 1'b0 || rf_we !== 1'b1 || rf_wa !== 5'd10 || rf_wd !== 64'hA0A0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL starve_held: st=%0b we=%0b wa=%0d wd=%h busy=%0b want 0 1 10 a0a0 0",
                     stall_pipe, rf_we, rf_wa, rf_wd, busy);
        end
    endtask

    task automatic test_supersede;
        drive(0, 0, 0, 1, 4, 64'hAAAA);
        drive(1, 4, 64'hBBBB, 0, 0, 0);
        checks++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd4 || rf_wd !== 64'hBBBB) begin
            errors++;
            $display("FAIL supersede_write: we=%0b wa=%0d wd=%h want 1 4 bbbb", rf_we, rf_wa, rf_wd);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            checks++;
            if (rf_we !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL supersede_stale: we=%0b wd=%h busy=%0b want 0 0", rf_we, rf_wd, busy);
            end
        end
    endtask

    task automatic test_mid_reset;
        drive(0, 0, 0, 1, 12, 64'h5555);
        drive(1, 1, 64'h11, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rf_we !== 1'b0 || stall_pipe !== 1'b0) begin
            errors++;
            $display("FAIL hold_reset: busy=%0b we=%0b st=%0b want 0 0 0", busy, rf_we, stall_pipe);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            checks++;
            if (rf_we !== 1'b0) begin
                errors++;
                $display("FAIL hold_reset_stale: we=%0b wa=%0d wd=%h want 0", rf_we, rf_wa, rf_wd);
            end
        end
        drive(0, 0, 0, 1, 9, 64'h7777);
        for (int i = 1; i <= 3; i++) drive(1, 5'(i), 64'(i), 0, 0, 0);
        drive(1, 2, 64'h22, 0, 0, 0);
        checks++;
        if (stall_pipe !== 1'b1) begin
            errors++;
            $display("FAIL force_pre: st=%0b want 1", stall_pipe);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (stall_pipe !== 1'b0 || busy !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL force_reset: st=%0b busy=%0b we=%0b want 0 0 0", stall_pipe, busy, rf_we);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            checks++;
            if (rf_we !== 1'b0) begin
                errors++;
                $display("FAIL force_reset_stale: we=%0b wd=%h want 0", rf_we, rf_wd);
            end
        end
    endtask

    function automatic logic [4:0] pick_rd();
        int unsigned r;
        r = $urandom_range(0, 7);
        return (r == 7) ? 5'd31 : 5'(r % 4 + 1);
    endfunction

    // Reference model: at most one buffered entry with an age counter
    task automatic test_random;
        logic [4:0]  q_rd[$];
        logic [63:0] q_data[$];
        int          waited;
        bit          forcing;
        bit          live;
        bit          pr;
        logic        e_we, e_st, e_rdy, e_busy;
        logic [4:0]  e_wa;
        logic [63:0] e_wd;
        live = 0;
        waited = 0;
        forcing = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            reset          = (cyc == 0 || $urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            wb_regwrite_in = ($urandom_range(0, 9) < 7);
            wb_rd_in       = pick_rd();
            wb_dw_in       = {$urandom, $urandom};
            mc_valid       = $urandom_range(0, 1);
            mc_rd          = pick_rd();
            mc_data        = {$urandom, $urandom};
            if (!reset) begin
                q_rd.delete();
                q_data.delete();
                live = 0;
                waited = 0;
                forcing = 0;
            end
            #1;
            pr = wb_regwrite_in && wb_rd_in != 31;
            {e_we, e_st, e_rdy, e_busy, e_wa, e_wd} = '0;
            if (reset && live) begin
                e_wa = wb_rd_in;
                e_wd = wb_dw_in;
                e_we = pr;
                if (forcing) begin
                    e_st = 1;
                    e_busy = 1;
                    e_we = (q_rd[0] != 31);
                    e_wa = q_rd[0];
                    e_wd = q_data[0];
                end else if (q_rd.size() == 0) begin
                    e_rdy = 1;
                end else begin
                    e_busy = 1;
                    if (q_rd[0] != 31 && !pr) begin
                        e_we = 1;
                        e_wa = q_rd[0];
                        e_wd = q_data[0];
                    end
                end
            end
            checks++;
            if (rf_we !== e_we || stall_pipe !== e_st || mc_ready !== e_rdy || busy !== e_busy) begin
                errors++;
                $display("FAIL rand_ctl cyc=%0d: we=%0b st=%0b rdy=%0b busy=%0b want %0b %0b %0b %0b",
                         cyc, rf_we, stall_pipe, mc_ready, busy, e_we, e_st, e_rdy, e_busy);
            end
            if (e_we || !reset) begin
                checks++;
                if (rf_wa !== e_wa || rf_wd !== e_wd) begin
                    errors++;
                    $display("FAIL rand_data cyc=%0d: wa=%0d wd=%h want %0d %h",
                             cyc, rf_wa, rf_wd, e_wa, e_wd);
                end
            end
            if (reset && !live) begin
                live = 1;
            end else if (reset) begin
                if (forcing) begin
                    q_rd.delete();
                    q_data.delete();
                    forcing = 0;
                    waited = 0;
                end else if (q_rd.size() == 0) begin
                    if (mc_valid) begin
                        q_rd.push_back(mc_rd);
                        q_data.push_back(mc_data);
                        waited = 0;
                    end
                end else if (q_rd[0] == 31 || !pr || wb_rd_in == q_rd[0]) begin
                    q_rd.delete();
                    q_data.delete();
                end else begin
                    waited++;
                    if (waited >= STARVE_MAX) forcing = 1;
                end
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle_write();
        idle_cycles(2);
        test_drain();
        idle_cycles(2);
        test_starve();
        idle_cycles(2);
        test_supersede();
        idle_cycles(2);
        test_mid_reset();
        idle_cycles(2);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Arbitrates the single register-file write port between the MEM/WB pipeline register output and a multi-cycle execution unit (multiply/divide) that returns results out of band. It sits between the MEM/WB stage and the 32×64 register file and holds one multi-cycle result in a buffer. It grants the port to the pipeline by default and forces a one-cycle pipeline stall when a buffered result has waited too long. X31 (XZR) writes are suppressed from both sources.

## Interface
- STARVE_MAX, 3: number of consecutive blocked cycles a buffered result tolerates before FORCE; legal range 1–15.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- wb_rd_in  in  5  destination register from MEM/WB.
- wb_dw_in  in  64  write data from MEM/WB.
- wb_regwrite_in  in  1  MEM/WB RegWrite control.
- mc_valid  in  1  multi-cycle unit presents a result.
- mc_rd  in  5  result destination register.
- mc_data  in  64  result data.
- mc_ready  out  1  arbiter accepts a result this cycle.
- rf_we  out  1  register-file write enable.
- rf_wa  out  5  register-file write address.
- rf_wd  out  64  register-file write data.
- stall_pipe  out  1  upstream must freeze; MEM/WB re-presents the same instruction next cycle.
- busy  out  1  buffer holds a result.

## Operation
- States: IDLE (buffer empty), HOLD (buffer full, waiting), FORCE (buffer written, pipeline stalled).
- pipe_req = wb_regwrite_in && wb_rd_in != 31. buf_req = buffer valid && buf_rd != 31.
- IDLE:
  - mc_ready=1.
  - Pipeline writes if pipe_req.
  - If mc_valid, capture {mc_rd, mc_data} at the edge, clear the starve counter, and go to HOLD.
- HOLD (mc_ready=0, busy=1):
  - buf_rd == 31: drop the entry without writing and go to IDLE.
  - !pipe_req: write the buffer to the port and go to IDLE.
  - pipe_req && wb_rd_in == buf_rd: pipeline writes. The buffered entry is older, so it is superseded: discard it and go to IDLE.
  - pipe_req, different register: pipeline writes and the counter increments. If the counter was STARVE_MAX-1, go to FORCE; otherwise stay in HOLD.
- FORCE:
  - stall_pipe=1 and the buffer writes the port. Pipeline inputs are ignored this cycle.
  - Clear the buffer and counter, then go to IDLE.
  - The stalled MEM/WB instruction is written in the following IDLE cycle.
- Write-port mux: FORCE or buffer grant in HOLD → rf_wa=buf_rd, rf_wd=buf_data. Otherwise rf_wa=wb_rd_in, rf_wd=wb_dw_in.
- rf_we is 1 only on a granted, non-X31 write. rf_wa and rf_wd are don't-care when rf_we=0; drive them from the pipeline inputs.
- Counter width is 4 bits and saturates; it never wraps because FORCE triggers first.
- In IDLE, a write and a capture in the same cycle are allowed.
- The buffer never accepts while full.

## Timing
- Reset value of every output: rf_we=0, stall_pipe=0, mc_ready=0, busy=0, rf_wa=0, rf_wd=0. State is IDLE, buffer invalid, counter 0.
- Deassertion of reset takes effect at the next clk edge. mc_ready=1 from the first cycle after reset.
- Outputs are combinational from the current state, buffer, and same-cycle inputs. The write lands at the register file on the next edge.
- Accept latency: mc_valid && mc_ready is sampled at edge N, and the earliest buffer write is in cycle N+1.
- Worst-case result latency is STARVE_MAX+1 cycles after capture. stall_pipe is never longer than 1 cycle per captured result.
- Reset asserted mid-HOLD or mid-FORCE discards the buffered result silently. stall_pipe drops immediately because reset is asynchronous.

## Test plan
- Reset check: hold reset=0 with random inputs → all outputs 0. Release reset → mc_ready=1 next cycle.
- Idle write-back: pipeline writes X5=0xDEAD, no mc → rf_we=1, rf_wa=5, rf_wd=0xDEAD. Repeat with wb_rd_in=31 → rf_we=0.
- Buffer drains in gap: mc result X7=0x1234 accepted, next cycle wb_regwrite_in=0 → rf_we=1, rf_wa=7, rf_wd=0x1234, busy returns to 0.
- Starvation with STARVE_MAX=3: mc result X9 accepted, pipeline writes X1, X2, X3 on 3 consecutive cycles → next cycle stall_pipe=1, rf_wa=9. Following cycle the held pipeline write lands, stall_pipe=0.
- Supersede: buffer holds X4=0xAAAA, pipeline writes X4=0xBBBB → rf_wd=0xBBBB, buffer cleared, no later write of 0xAAAA.
- Mid-operation reset: assert reset in HOLD → busy=0 immediately. After release, no write of the old buffered value ever appears.
